uart_rx: RTL and testbench
==========================

# uart_rx

Receive-side serializer for the UART link: oversamples the asynchronous serial line, detects the start bit, centre-samples `DATA_WIDTH` data bits LSB-first plus one stop bit, and presents each byte on a valid/ready output port. It is the peer of the transmitter on the far end of the link and feeds the RX-side consumer logic (FIFO or command decoder). Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `DATA_WIDTH`, 8: bits per frame, sent LSB first.
- `BAUD_RATE`, 115_200: line bit rate.
- `CLK_FREQ`, 50_000_000: `clk` frequency in Hz.
- Derived, not overridable: `PULSE_WIDTH = CLK_FREQ / BAUD_RATE` (434 at defaults); `HALF_PULSE_WIDTH = PULSE_WIDTH / 2` (217).

- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `ena`  in  1  clock enable; all state, including the synchronizer, advances only on edges where `ena`=1.
- `rx_signal`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  DATA_WIDTH  received byte; stable while `rx_valid`=1.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts the byte.
- `rx_frame_err`  out  1  1-cycle pulse when the stop bit is sampled low.
- `rx_overrun`  out  1  1-cycle pulse when a good frame is dropped because the output is still full.

## Operation
- Synchronizer: 2 flops, both reset to 1. All decisions use the second flop (`rx_sync`).
- Bit-timing counter: `CLK_CNT`, `$clog2(PULSE_WIDTH)+1` bits. Data counter: `$clog2(DATA_WIDTH)` bits (minimum 1). Shift register: `DATA_WIDTH` bits. Each new bit enters at the MSB and the register shifts right.
- States:
  - STT_IDLE: when `rx_sync`=0, load `CLK_CNT`=`HALF_PULSE_WIDTH`-1 and go to STT_START.
  - STT_START: decrement `CLK_CNT` while it is >0. At 0, sample the line:
    - sample 0: load `CLK_CNT`=`PULSE_WIDTH`-1, clear the data counter, go to STT_DATA.
    - sample 1: treat as a glitch and return to STT_IDLE. No error is flagged.
  - STT_DATA: count down. At 0, shift the sample in and reload `PULSE_WIDTH`-1. After bit `DATA_WIDTH`-1, go to STT_STOP; otherwise increment the data counter.
  - STT_STOP: count down. At 0, sample the line:
    - sample 1: deliver the byte and go to STT_IDLE.
    - sample 0: pulse `rx_frame_err`, discard the byte, go to STT_BREAK.
  - STT_BREAK: wait for `rx_sync`=1, then go to STT_IDLE. A held-low line therefore produces exactly one error.
  - Any undefined encoding: go to STT_IDLE.
- Delivery rules:
  - If `rx_valid`=0, or `rx_valid`&&`rx_ready` in the same cycle: `rx_data` takes the shift register and `rx_valid`=1. No overrun.
  - Otherwise: pulse `rx_overrun`; `rx_data` and `rx_valid` are unchanged and the new byte is lost.
- Handshake: when `rx_valid`&&`rx_ready` on an `ena` edge, `rx_valid` clears next cycle unless a delivery coincides.
- `ena`=0: complete freeze. Error pulses are not extended and no handshake completes.

## Timing
- Reset values:
  - outputs: `rx_data`=0, `rx_valid`=0, `rx_frame_err`=0, `rx_overrun`=0.
  - internal: state STT_IDLE, counters 0.
- Reset mid-frame: the partial frame is abandoned with no pulses. The receiver re-arms in STT_IDLE. If the line is low at that point, it is treated as a new start bit.
- Sample schedule, with t = the enabled edge at which STT_IDLE sees `rx_sync`=0:
  - start-bit check at t+`HALF_PULSE_WIDTH` (t+217 at defaults).
  - data bit k at t+`HALF_PULSE_WIDTH`+(k+1)·`PULSE_WIDTH`.
  - stop bit at t+`HALF_PULSE_WIDTH`+(`DATA_WIDTH`+1)·`PULSE_WIDTH` (t+4123 at defaults).
- `rx_valid`, `rx_frame_err` and `rx_overrun` are registered and visible the cycle after the stop-bit sample.
- Line edge to `rx_sync`: 2 enabled cycles.
- Tolerates ±4% bit-period mismatch at defaults.
- The next start bit is accepted on the first enabled edge after returning to STT_IDLE. Back-to-back frames with a 1-bit stop are supported.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state` enum typedef (STT_IDLE, STT_START, STT_DATA, STT_STOP, STT_BREAK; 3-bit encoding).
  - Helper functions computing `PULSE_WIDTH` and `HALF_PULSE_WIDTH` from `CLK_FREQ` and `BAUD_RATE`, shared with the TX side.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset value 1 and `ena` gating. Instantiated once.

## Test plan
- Frame 0xA5 at 434-cycle bits, `rx_ready`=1 → `rx_valid` for 1 cycle with `rx_data`=0xA5, t+4124 after start; no error pulses.
- 100-cycle low glitch on an idle line → state back in STT_IDLE; no `rx_valid` and no `rx_frame_err`.
- Frame 0x3C with stop bit low, line then held low for 2000 cycles → exactly one `rx_frame_err` pulse, `rx_valid`=0; a following 0x81 frame is received correctly.
- Frames 0x11 then 0x22 with `rx_ready`=0 → `rx_data` stays 0x11, one `rx_overrun` pulse. Raising `rx_ready` then clears `rx_valid`. Variant: ready asserted exactly in the stop-sample cycle → 0x22 delivered, no overrun.
- `ena` toggling 1-of-2 cycles with 868-cycle bits, frame 0x5A → 0x5A received.
- `reset` asserted mid-data, line then idle → all outputs 0, no pulses; next frame 0xF0 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and bit-timing helpers
package uart_pkg;

  typedef enum logic [2:0] {
    STT_IDLE  = 3'd0,
    STT_START = 3'd1,
    STT_DATA  = 3'd2,
    STT_STOP  = 3'd3,
    STT_BREAK = 3'd4
  } uart_rx_state;

  function automatic int uart_pulse_width(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int uart_half_pulse_width(input int clk_freq, input int baud_rate);
    return uart_pulse_width(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop line synchronizer, idles high, clock-enable gated
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic ena,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else if (ena) begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with valid/ready byte output
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115_200,
  parameter int CLK_FREQ   = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic                  rx_signal,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_frame_err,
  output logic                  rx_overrun
);

  localparam int PULSE_WIDTH      = uart_pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int HALF_PULSE_WIDTH = uart_half_pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;
  localparam int DCNT_W           = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0]  FULL_RELOAD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0]  HALF_RELOAD = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [DCNT_W-1:0] LAST_BIT    = DCNT_W'(DATA_WIDTH - 1);

  uart_rx_state          state, state_nxt;
  logic [CNT_W-1:0]      clk_cnt, clk_cnt_nxt;
  logic [DCNT_W-1:0]     data_cnt, data_cnt_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_reg_nxt;
  logic                  rx_sync;
  logic                  frame_done;
  logic                  frame_bad;

  uart_rx_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .async_in (rx_signal),
    .sync_out (rx_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= STT_IDLE;
      clk_cnt   <= '0;
      data_cnt  <= '0;
      shift_reg <= '0;
    end else if (ena) begin
      state     <= state_nxt;
      clk_cnt   <= clk_cnt_nxt;
      data_cnt  <= data_cnt_nxt;
      shift_reg <= shift_reg_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    clk_cnt_nxt   = clk_cnt;
    data_cnt_nxt  = data_cnt;
    shift_reg_nxt = shift_reg;
    frame_done    = 1'b0;
    frame_bad     = 1'b0;
    case (state)
      STT_IDLE: begin
        if (!rx_sync) begin
          clk_cnt_nxt = HALF_RELOAD;
          state_nxt   = STT_START;
        end
      end
      STT_START: begin
        if (clk_cnt != '0) begin
          clk_cnt_nxt = clk_cnt - 1'b1;
        end else if (!rx_sync) begin
          clk_cnt_nxt  = FULL_RELOAD;
          data_cnt_nxt = '0;
          state_nxt    = STT_DATA;
        end else begin
          // Line was back high at mid-start: a glitch, silently ignored.
          state_nxt = STT_IDLE;
        end
      end
      STT_DATA: begin
        if (clk_cnt != '0) begin
          clk_cnt_nxt = clk_cnt - 1'b1;
        end else begin
          shift_reg_nxt                 = shift_reg >> 1;
          shift_reg_nxt[DATA_WIDTH-1]   = rx_sync;
          clk_cnt_nxt                   = FULL_RELOAD;
          if (data_cnt == LAST_BIT) begin
            state_nxt = STT_STOP;
          end else begin
            data_cnt_nxt = data_cnt + 1'b1;
          end
        end
      end
      STT_STOP: begin
        if (clk_cnt != '0) begin
          clk_cnt_nxt = clk_cnt - 1'b1;
        end else if (rx_sync) begin
          frame_done = 1'b1;
          state_nxt  = STT_IDLE;
        end else begin
          frame_bad = 1'b1;
          state_nxt = STT_BREAK;
        end
      end
      STT_BREAK: begin
        // Hold here until the line recovers so a long break reports only once.
        if (rx_sync) begin
          state_nxt = STT_IDLE;
        end
      end
      default: begin
        state_nxt = STT_IDLE;
      end
    endcase
  end

  // Pulses are gated with ena so a stalled clock enable never stretches them.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= ena & frame_bad;
      rx_overrun   <= ena & frame_done & rx_valid & ~rx_ready;
      if (ena) begin
        if (frame_done && (!rx_valid || rx_ready)) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
          rx_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int P   = 50_000_000 / 115_200;
  localparam int H   = P / 2;
  localparam int LAT = 3 + H + (DW + 1) * P;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ena = 1'b1;
  logic          rx_signal = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_frame_err;
  logic          rx_overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int vrise_cnt = 0;
  int vrise_cyc = 0;
  int vhigh_cnt = 0;
  int start_cyc = 0;
  logic prev_valid = 1'b0;
  logic done = 1'b0;
  logic [DW-1:0] got_q[$];

  uart_rx #(.DATA_WIDTH(DW), .BAUD_RATE(115_200), .CLK_FREQ(50_000_000)) dut (
    .clk          (clk),
    .reset        (reset),
    .ena          (ena),
    .rx_signal    (rx_signal),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_frame_err === 1'b1) ferr_cnt++;
    if (rx_overrun === 1'b1) ovr_cnt++;
    if (rx_valid === 1'b1) vhigh_cnt++;
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      vrise_cnt++;
      vrise_cyc = cyc;
    end
    if (rx_valid === 1'b1 && rx_ready && ena && !reset) got_q.push_back(rx_data);
    prev_valid = rx_valid;
  end

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx_signal = v;
    idle(n);
  endtask

  task automatic send_frame(input logic [DW-1:0] b, input logic stop, input int n);
    start_cyc = cyc;
    drive_bit(1'b0, n);
    for (int k = 0; k < DW; k++) drive_bit(b[k], n);
    drive_bit(stop, n);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(4);
    checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_rx_data got %0h expected 0", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b expected 0", rx_valid); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b expected 0", rx_frame_err); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b expected 0", rx_overrun); end
    checks++; if (dut.state !== STT_IDLE) begin errors++; $display("FAIL reset_state got %0d expected %0d", dut.state, STT_IDLE); end
    reset = 1'b0;
    idle(4);
  endtask

  task automatic test_single_frame;
    int n0 = got_q.size();
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    int v0 = vrise_cnt;
    int h0 = vhigh_cnt;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, P);
    idle(20);
    checks++; if (vrise_cnt - v0 != 1) begin errors++; $display("FAIL single_valid_events got %0d expected 1", vrise_cnt - v0); end
    checks++; if (vrise_cyc - start_cyc != LAT) begin errors++; $display("FAIL single_latency got %0d expected %0d", vrise_cyc - start_cyc, LAT); end
    checks++; if (vhigh_cnt - h0 != 1) begin errors++; $display("FAIL single_valid_width got %0d expected 1", vhigh_cnt - h0); end
    checks++; if (got_q.size() != n0 + 1 || got_q[n0] !== 8'hA5) begin errors++; $display("FAIL single_data got %0d bytes expected 1 byte a5", got_q.size() - n0); end
    checks++; if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin errors++; $display("FAIL single_pulses got ferr %0d ovr %0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_glitch;
    int f0 = ferr_cnt;
    int v0 = vrise_cnt;
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 600);
    checks++; if (vrise_cnt - v0 != 0) begin errors++; $display("FAIL glitch_valid got %0d expected 0", vrise_cnt - v0); end
    checks++; if (ferr_cnt - f0 != 0) begin errors++; $display("FAIL glitch_frame_err got %0d expected 0", ferr_cnt - f0); end
    checks++; if (dut.state !== STT_IDLE) begin errors++; $display("FAIL glitch_state got %0d expected %0d", dut.state, STT_IDLE); end
  endtask

  task automatic test_frame_error;
    int f0 = ferr_cnt;
    int v0 = vrise_cnt;
    int n0;
    rx_ready = 1'b1;
    send_frame(8'h3C, 1'b0, P);
    drive_bit(1'b0, 2000);
    drive_bit(1'b1, P);
    checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_count got %0d expected 1", ferr_cnt - f0); end
    checks++; if (vrise_cnt - v0 != 0 || rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got %0d events expected 0", vrise_cnt - v0); end
    n0 = got_q.size();
    send_frame(8'h81, 1'b1, P);
    idle(20);
    checks++; if (got_q.size() != n0 + 1 || got_q[n0] !== 8'h81) begin errors++; $display("FAIL ferr_recover got %0d bytes expected 1 byte 81", got_q.size() - n0); end
  endtask

  task automatic test_random_frames;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] b;
    int n0 = got_q.size();
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = DW'($urandom);
      send_frame(b, 1'b1, P - 8 + int'($urandom_range(0, 16)));
      exp_q.push_back(b);
      idle(int'($urandom_range(0, 1)) * int'($urandom_range(0, P / 4)));
    end
    idle(20);
    checks++; if (got_q.size() - n0 != exp_q.size()) begin errors++; $display("FAIL random_count got %0d expected %0d", got_q.size() - n0, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (n0 + i >= got_q.size() || got_q[n0 + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_byte%0d got %0h expected %0h", i, (n0 + i < got_q.size()) ? got_q[n0 + i] : 8'h00, exp_q[i]);
      end
    end
    checks++; if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin errors++; $display("FAIL random_pulses got ferr %0d ovr %0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_overrun;
    int n0 = got_q.size();
    int o0 = ovr_cnt;
    int c;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, P);
    send_frame(8'h22, 1'b1, P);
    idle(20);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL ovr_hold got valid %b data %0h expected 1 11", rx_valid, rx_data); end
    checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL ovr_count got %0d expected 1", ovr_cnt - o0); end
    rx_ready = 1'b1;
    idle(1);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b expected 0", rx_valid); end
    checks++; if (got_q.size() != n0 + 1 || got_q[n0] !== 8'h11) begin errors++; $display("FAIL ovr_consumed got %0d bytes expected 1 byte 11", got_q.size() - n0); end
    n0 = got_q.size();
    o0 = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, P);
    idle(5);
    c = cyc;
    fork
      send_frame(8'h22, 1'b1, P);
      begin
        repeat (c - cyc + 2 + H + (DW + 1) * P) @(posedge clk);
        #1;
        rx_ready = 1'b1;
      end
    join
    idle(20);
    checks++; if (ovr_cnt - o0 != 0) begin errors++; $display("FAIL ovr_edge_count got %0d expected 0", ovr_cnt - o0); end
    checks++; if (got_q.size() != n0 + 2 || got_q[n0] !== 8'h11 || got_q[n0 + 1] !== 8'h22) begin errors++; $display("FAIL ovr_edge_data got %0d bytes expected 2 bytes 11 22", got_q.size() - n0); end
  endtask

  task automatic test_ena_toggle;
    int n0 = got_q.size();
    rx_ready = 1'b1;
    done = 1'b0;
    fork
      begin
        send_frame(8'h5A, 1'b1, 2 * P);
        done = 1'b1;
      end
      begin
        while (!done) begin
          ena = ~ena;
          idle(1);
        end
      end
    join
    ena = 1'b1;
    idle(20);
    checks++; if (got_q.size() != n0 + 1 || got_q[n0] !== 8'h5A) begin errors++; $display("FAIL ena_data got %0d bytes expected 1 byte 5a", got_q.size() - n0); end
  endtask

  task automatic test_reset_mid_frame;
    int n0 = got_q.size();
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    int v0 = vrise_cnt;
    rx_ready = 1'b1;
    drive_bit(1'b0, P);
    drive_bit(1'b1, P);
    drive_bit(1'b0, P / 2);
    rx_signal = 1'b1;
    reset = 1'b1;
    idle(3);
    checks++; if (rx_valid !== 1'b0 || rx_data !== '0) begin errors++; $display("FAIL midrst_out got valid %b data %0h expected 0 0", rx_valid, rx_data); end
    reset = 1'b0;
    idle(2 * P);
    checks++; if (dut.state !== STT_IDLE) begin errors++; $display("FAIL midrst_state got %0d expected %0d", dut.state, STT_IDLE); end
    checks++; if (vrise_cnt - v0 != 0 || ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin errors++; $display("FAIL midrst_pulses got valid %0d ferr %0d ovr %0d expected 0 0 0", vrise_cnt - v0, ferr_cnt - f0, ovr_cnt - o0); end
    send_frame(8'hF0, 1'b1, P);
    idle(20);
    checks++; if (got_q.size() != n0 + 1 || got_q[n0] !== 8'hF0) begin errors++; $display("FAIL midrst_next got %0d bytes expected 1 byte f0", got_q.size() - n0); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset;
    test_single_frame;
    test_glitch;
    test_frame_error;
    test_random_frames;
    test_overrun;
    test_ena_toggle;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
